// File: rtl/regfile_pkg.sv
`default_nettype none
// =============================================================================
// regfile_pkg : shared constants and helpers for the multi-port register file
// Rev 1.0
// =============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ZERO_REG = 31;

  localparam int NUM_WR  = 2;
  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;

  // A register index that can hold state: inside the file and not the zero register.
  function automatic logic reg_writable(input int idx, input int num_regs, input int zero_reg);
    return (idx < num_regs) && (idx != zero_reg);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// =============================================================================
// regfile_rdport : one combinational read port with write forwarding and busy lookup
// Rev 1.0
// =============================================================================
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = 5
) (
  input  logic                             kill,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]    wr_data,
  input  logic                             issue_en,
  input  logic [ADDR_W-1:0]                issue_reg,
  output logic [DATA_W-1:0]                data,
  output logic                             busy_out
);

  logic              in_range;
  logic              is_zero;
  logic              hit_alu;
  logic              hit_load;
  logic              issue_hit;
  logic [DATA_W-1:0] stored_data;
  logic              stored_busy;

  always_comb begin
    in_range    = int'(addr) < NUM_REGS;
    is_zero     = int'(addr) == ZERO_REG;
    hit_alu     = (BYPASS != 0) && wr_en[WB_ALU]  && (wr_addr[WB_ALU]  == addr);
    hit_load    = (BYPASS != 0) && wr_en[WB_LOAD] && (wr_addr[WB_LOAD] == addr);
    issue_hit   = issue_en && (issue_reg == addr);
    stored_data = '0;
    stored_busy = 1'b0;
    if (in_range) begin
      stored_data = regs[addr];
      stored_busy = busy[addr];
    end

    data     = stored_data;
    busy_out = stored_busy;
    if (hit_load) begin
      data = wr_data[WB_LOAD];
    end else if (hit_alu) begin
      data = wr_data[WB_ALU];
    end
    // Forwarded view mirrors next-cycle scoreboard: the write clears, a new issue re-sets.
    if (hit_load || hit_alu) begin
      busy_out = issue_hit;
    end

    if (kill || !in_range || is_zero) begin
      data     = '0;
      busy_out = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// =============================================================================
// regfile_mp : flip-flop register file, NUM_RD read / 2 write ports, busy scoreboard
// Rev 1.0
// =============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = DEF_ZERO_REG,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  ReadRegister,
  output logic [NUM_RD-1:0][DATA_W-1:0]  ReadData,
  output logic [NUM_RD-1:0]              ReadBusy,
  input  logic [NUM_WR-1:0]              RegWrite,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  WriteRegister,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  WriteData,
  input  logic                           IssueEn,
  input  logic [ADDR_W-1:0]              IssueReg
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_WR-1:0]               wr_en;
  logic                            issue_en;

  // Qualified enables: zero-register and out-of-range targets never reach state.
  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wr_en[p] = RegWrite[p] && reg_writable(int'(WriteRegister[p]), NUM_REGS, ZERO_REG);
    end
    issue_en = IssueEn && reg_writable(int'(IssueReg), NUM_REGS, ZERO_REG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en[WB_LOAD] && (int'(WriteRegister[WB_LOAD]) == r)) begin
          regs[r] <= WriteData[WB_LOAD];
        end else if (wr_en[WB_ALU] && (int'(WriteRegister[WB_ALU]) == r)) begin
          regs[r] <= WriteData[WB_ALU];
        end

        if (issue_en && (int'(IssueReg) == r)) begin
          busy[r] <= 1'b1;
        end else if ((wr_en[WB_LOAD] && (int'(WriteRegister[WB_LOAD]) == r)) ||
                     (wr_en[WB_ALU]  && (int'(WriteRegister[WB_ALU])  == r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rdport
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .ADDR_W   (ADDR_W)
    ) u_rdport (
      .kill      (reset),
      .addr      (ReadRegister[i]),
      .regs      (regs),
      .busy      (busy),
      .wr_en     (wr_en),
      .wr_addr   (WriteRegister),
      .wr_data   (WriteData),
      .issue_en  (issue_en),
      .issue_reg (IssueReg),
      .data      (ReadData[i]),
      .busy_out  (ReadBusy[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// =============================================================================
// tb_regfile_mp : directed bench for regfile_mp, default and 32b/16-reg/no-bypass builds
// Rev 1.0
// =============================================================================
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default build: 64b, 32 regs, 2 read ports, bypass, zero reg 31
  logic [1:0][4:0]  a_rr;
  logic [1:0][63:0] a_rd;
  logic [1:0]       a_rb;
  logic [1:0]       a_we;
  logic [1:0][4:0]  a_wa;
  logic [1:0][63:0] a_wd;
  logic             a_ie;
  logic [4:0]       a_ir;

  regfile_mp dut_a (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister  (a_rr),
    .ReadData      (a_rd),
    .ReadBusy      (a_rb),
    .RegWrite      (a_we),
    .WriteRegister (a_wa),
    .WriteData     (a_wd),
    .IssueEn       (a_ie),
    .IssueReg      (a_ir)
  );

  // Small build: 32b, 16 regs, 3 read ports, no bypass, zero reg 15
  logic [2:0][3:0]  b_rr;
  logic [2:0][31:0] b_rd;
  logic [2:0]       b_rb;
  logic [1:0]       b_we;
  logic [1:0][3:0]  b_wa;
  logic [1:0][31:0] b_wd;
  logic             b_ie;
  logic [3:0]       b_ir;

  regfile_mp #(
    .DATA_W   (32),
    .NUM_REGS (16),
    .NUM_RD   (3),
    .ZERO_REG (15),
    .BYPASS   (0)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister  (b_rr),
    .ReadData      (b_rd),
    .ReadBusy      (b_rb),
    .RegWrite      (b_we),
    .WriteRegister (b_wa),
    .WriteData     (b_wd),
    .IssueEn       (b_ie),
    .IssueReg      (b_ir)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] apat(input int i);
    return 64'(i) * 64'h0000_0102_0408_0001;
  endfunction

  function automatic logic [31:0] bpat(input int i);
    return 32'(i + 1) * 32'h0101_0101;
  endfunction

  initial begin
    reset = 1'b0;
    a_rr = '0; a_we = '0; a_wa = '0; a_wd = '0; a_ie = 1'b0; a_ir = '0;
    b_rr = '0; b_we = '0; b_wa = '0; b_wd = '0; b_ie = 1'b0; b_ir = '0;
    #1 reset = 1'b1;
    #1;
    check("a_rst_data", a_rd[0], 64'd0);
    check("a_rst_busy", 64'(a_rb), 64'd0);
    check("b_rst_data", 64'(b_rd[0]), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // ---------------- default build ----------------
    for (int i = 0; i <= 30; i++) begin
      a_rr[0] = 5'(i);
      #1 check($sformatf("a_pre%0d", i), a_rd[0], 64'd0);
      a_we = 2'b01; a_wa[0] = 5'(i); a_wd[0] = apat(i);
      tick();
    end
    a_we = '0;
    for (int i = 0; i <= 30; i++) begin
      a_rr[0] = 5'(i);
      a_rr[1] = 5'(30 - i);
      #1;
      check($sformatf("a_rd0_%0d", i), a_rd[0], apat(i));
      check($sformatf("a_rd1_%0d", 30 - i), a_rd[1], apat(30 - i));
    end

    // Zero register swallows writes
    a_we = 2'b01; a_wa[0] = 5'd31; a_wd[0] = 64'hA0; a_rr[0] = 5'd31;
    #1;
    check("a_zero_byp", a_rd[0], 64'd0);
    check("a_zero_bsy", 64'(a_rb[0]), 64'd0);
    tick();
    a_we = '0;
    #1 check("a_zero_rd", a_rd[0], 64'd0);

    // Same-register double write: load port wins
    a_we = 2'b11; a_wa[0] = 5'd12; a_wa[1] = 5'd12;
    a_wd[0] = 64'hAAAA; a_wd[1] = 64'hBBBB; a_rr[1] = 5'd12;
    #1 check("a_dual_byp", a_rd[1], 64'hBBBB);
    tick();
    a_we = '0;
    #1 check("a_dual_rd", a_rd[1], 64'hBBBB);

    // Scoreboard set by issue, cleared by writeback
    a_ie = 1'b1; a_ir = 5'd5;
    tick();
    a_ie = 1'b0; a_rr[0] = 5'd5;
    #1;
    check("a_busy_set", 64'(a_rb[0]), 64'd1);
    check("a_busy_data", a_rd[0], apat(5));
    a_we = 2'b10; a_wa[1] = 5'd5; a_wd[1] = 64'h55;
    #1;
    check("a_wb_byp", a_rd[0], 64'h55);
    check("a_wb_bsy", 64'(a_rb[0]), 64'd0);
    tick();
    a_we = '0;
    #1;
    check("a_wb_bsy_nx", 64'(a_rb[0]), 64'd0);
    check("a_wb_data", a_rd[0], 64'h55);

    // Issue and write collide: set wins, data still lands
    a_ie = 1'b1; a_ir = 5'd7; a_we = 2'b01; a_wa[0] = 5'd7; a_wd[0] = 64'h77;
    tick();
    a_ie = 1'b0; a_we = '0; a_rr[0] = 5'd7;
    #1;
    check("a_coll_bsy", 64'(a_rb[0]), 64'd1);
    check("a_coll_data", a_rd[0], 64'h77);

    // Issue to the zero register is ignored
    a_ie = 1'b1; a_ir = 5'd31;
    tick();
    a_ie = 1'b0; a_rr[0] = 5'd31;
    #1 check("a_zero_iss", 64'(a_rb[0]), 64'd0);

    // Asynchronous reset mid-cycle
    a_rr[0] = 5'd3; a_rr[1] = 5'd7;
    #1;
    check("a_pre_rst_d", a_rd[0], apat(3));
    check("a_pre_rst_b", 64'(a_rb[1]), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("a_arst_d", a_rd[0], 64'd0);
    check("a_arst_b", 64'(a_rb[1]), 64'd0);
    a_we = 2'b10; a_wa[0] = 5'd10; a_wd[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    a_wa[1] = 5'd11; a_wd[1] = 64'h1111; a_ie = 1'b1; a_ir = 5'd11;
    a_rr[1] = 5'd11;
    #1 check("a_rst_byp", a_rd[1], 64'd0);
    tick();
    tick();
    a_we = '0; a_ie = 1'b0;
    reset = 1'b0;
    a_rr[0] = 5'd10;
    #1;
    check("a_post_r10", a_rd[0], 64'd0);
    check("a_post_r11", a_rd[1], 64'd0);
    check("a_post_b11", 64'(a_rb[1]), 64'd0);
    a_rr[0] = 5'd3;
    #1 check("a_post_r3", a_rd[0], 64'd0);
    tick();
    #1 check("a_post_b11_nx", 64'(a_rb[1]), 64'd0);

    // ---------------- small build, no bypass ----------------
    reset = 1'b1;
    #1 check("b_rst2", 64'(b_rd[0]), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i <= 14; i++) begin
      b_rr[0] = 4'(i);
      b_we = 2'b01; b_wa[0] = 4'(i); b_wd[0] = bpat(i);
      #1 check($sformatf("b_nobyp%0d", i), 64'(b_rd[0]), 64'd0);
      tick();
    end
    b_we = '0;
    for (int i = 0; i <= 14; i++) begin
      b_rr[0] = 4'(i);
      b_rr[1] = 4'(14 - i);
      b_rr[2] = 4'd15;
      #1;
      check($sformatf("b_rd0_%0d", i), 64'(b_rd[0]), 64'(bpat(i)));
      check($sformatf("b_rd1_%0d", 14 - i), 64'(b_rd[1]), 64'(bpat(14 - i)));
      check($sformatf("b_rd2_z%0d", i), 64'(b_rd[2]), 64'd0);
    end

    b_we = 2'b01; b_wa[0] = 4'd15; b_wd[0] = 32'hDEAD;
    tick();
    b_we = '0; b_rr[0] = 4'd15;
    #1 check("b_zero_rd", 64'(b_rd[0]), 64'd0);

    b_we = 2'b11; b_wa[0] = 4'd12; b_wa[1] = 4'd12;
    b_wd[0] = 32'h0AAA; b_wd[1] = 32'h0BBB; b_rr[0] = 4'd12;
    #1 check("b_dual_old", 64'(b_rd[0]), 64'(bpat(12)));
    tick();
    b_we = '0;
    #1 check("b_dual_rd", 64'(b_rd[0]), 64'h0BBB);

    b_ie = 1'b1; b_ir = 4'd5;
    tick();
    b_ie = 1'b0; b_rr[1] = 4'd5;
    #1 check("b_busy_set", 64'(b_rb[1]), 64'd1);
    b_we = 2'b10; b_wa[1] = 4'd5; b_wd[1] = 32'h55;
    #1;
    check("b_wb_bsy_old", 64'(b_rb[1]), 64'd1);
    check("b_wb_data_old", 64'(b_rd[1]), 64'(bpat(5)));
    tick();
    b_we = '0;
    #1;
    check("b_wb_bsy_nx", 64'(b_rb[1]), 64'd0);
    check("b_wb_data_nx", 64'(b_rd[1]), 64'h55);

    b_rr[0] = 4'd3;
    #1 check("b_pre_rst", 64'(b_rd[0]), 64'(bpat(3)));
    #2 reset = 1'b1;
    #1 check("b_arst", 64'(b_rd[0]), 64'd0);
    b_wa[0] = 4'd10; b_wd[0] = 32'hAAAA_AAAA;
    tick();
    reset = 1'b0;
    b_rr[0] = 4'd10;
    #1 check("b_post_r10", 64'(b_rd[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 64, SHALL set the register data width in bits.
REQ-003 Parameter NUM_REGS, default 32, SHALL set the register count; ADDR_W = clog2(NUM_REGS).
REQ-004 Parameter NUM_RD, default 2, SHALL set the number of read ports.
REQ-005 Parameter ZERO_REG, default 31, SHALL set the hardwired-zero register index.
REQ-006 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding (0 = plain read of the stored value).
REQ-007 Ports SHALL be as follows:
  - clk  in  1  rising-edge clock
  - reset  in  1  async active-high reset
  - ReadRegister  in  NUM_RD x ADDR_W  read addresses
  - ReadData  out  NUM_RD x DATA_W  read data, combinational
  - ReadBusy  out  NUM_RD  scoreboard busy bit of the addressed register
  - RegWrite  in  2  per-write-port enable (port 0 = ALU writeback, port 1 = load writeback)
  - WriteRegister  in  2 x ADDR_W  write addresses
  - WriteData  in  2 x DATA_W  write data
  - IssueEn  in  1  marks IssueReg as having an outstanding producer
  - IssueReg  in  ADDR_W  destination register being issued

Function
REQ-008 Each write port with RegWrite[p]=1 SHALL update WriteRegister[p] with WriteData[p] at the rising clk edge.
REQ-009 Writes to ZERO_REG SHALL be discarded; reads of ZERO_REG SHALL return 0 and ReadBusy=0, regardless of bypass.
REQ-010 If both write ports target the same non-zero register in one cycle, port 1 SHALL win.
REQ-011 Writes to addresses >= NUM_REGS SHALL be discarded; reads of such addresses SHALL return 0 with ReadBusy=0.
REQ-012 With BYPASS=1, a read whose address matches an enabled write in the same cycle SHALL return that write's data; port 1 SHALL take priority over port 0.
REQ-013 With BYPASS=0, a read SHALL return the value stored before the current edge.
REQ-014 Scoreboard: IssueEn=1 SHALL set busy[IssueReg] at the clock edge; an enabled write SHALL clear busy[WriteRegister].
REQ-015 When issue and write hit the same register in the same cycle, set SHALL win (the new producer stays outstanding).
REQ-016 IssueEn targeting ZERO_REG SHALL be ignored.
REQ-017 With BYPASS=1, ReadBusy SHALL be 0 when a same-cycle enabled write clears that register, unless a same-cycle issue also targets it.
REQ-018 Read paths SHALL have zero-cycle latency; writes and scoreboard updates SHALL be visible from the cycle after the edge.

Reset
REQ-019 On reset assertion, all registers SHALL clear to 0 and all busy bits to 0 immediately, without waiting for clk.
REQ-020 While reset is high, writes and issues SHALL be ignored, ReadData SHALL be 0 and ReadBusy SHALL be 0.
REQ-021 A reset that deasserts mid-operation SHALL leave no write or issue from the reset period pending.

Structure
REQ-022 Package regfile_pkg SHALL hold the default DATA_W, NUM_REGS and ZERO_REG constants, the write-port count (2) and the port index names (WB_ALU=0, WB_LOAD=1).
REQ-023 Sub-module regfile_rdport SHALL implement one read port (stored value, bypass compare and priority, zero-register and range masking, busy lookup), instanced NUM_RD times via generate.
REQ-024 Storage and scoreboard SHALL be flip-flop arrays; no memory macros.

Verification
REQ-025 Scenario: write 0xA0 to reg 31 via port 0, then read reg 31 -> ReadData=0, ReadBusy=0.
REQ-026 Scenario: fill regs 0..30 with i*0x0000010204080001 and read back on both ports -> every value matches; regs were 0 before the writes.
REQ-027 Scenario: same-cycle writes to reg 12, port 0 = 0xAAAA and port 1 = 0xBBBB -> next-cycle read of reg 12 = 0xBBBB; same-cycle bypass read = 0xBBBB.
REQ-028 Scenario: IssueEn on reg 5; next cycle read reg 5 -> busy=1; port 1 writes 0x55 -> same-cycle read gives 0x55 with busy=0 (BYPASS=1); the following cycle busy=0.
REQ-029 Scenario: issue and write to reg 7 in the same cycle -> busy[7]=1 afterwards and the data is updated.
REQ-030 Scenario: assert reset between clock edges after the regs are loaded -> all reads 0 and busy 0 immediately; RegWrite=0 with data 0xAAAA... to reg 10 -> reg 10 stays 0. Repeat the bench with DATA_W=32, NUM_REGS=16, NUM_RD=3, BYPASS=0 and ZERO_REG set to 15 (the default 31 lies outside a 16-register file).
